// File: rtl/ifetch_queue.sv
// Per-core instruction prefetch queue: drives this core's instruction-memory address
// slice, captures the word returned one cycle later, and buffers {pc, word} for the core.
module ifetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 16,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fetch_en,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic [AW-1:0] im_addr,
  input  logic [DW-1:0] im_data,
  output logic          ins_valid,
  output logic [DW-1:0] ins_data,
  output logic [AW-1:0] ins_pc,
  input  logic          ins_ready
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0] fetch_pc;
  logic          infl_v;
  logic [AW-1:0] infl_pc;

  logic [AW-1:0] ent_pc   [DEPTH];
  logic [DW-1:0] ent_data [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic [CW-1:0] occupancy;
  logic          issue;
  logic          push;
  logic          pop;

  // Space is reserved for the in-flight word, and a same-cycle pop is not credited,
  // so a push can never land on a full queue.
  assign occupancy = count + CW'(infl_v);
  assign issue     = fetch_en & ~redirect_valid & (occupancy < FULL);
  assign push      = infl_v & ~redirect_valid;
  assign pop       = ins_valid & ins_ready & ~redirect_valid;

  assign im_addr   = fetch_pc;
  assign ins_valid = (count != '0);
  assign ins_data  = ent_data[head];
  assign ins_pc    = ent_pc[head];

  // NOTE: all state here is sequential and uses non-blocking assignments, so every
  // read in this block sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= '0;
      infl_v   <= 1'b0;
      infl_pc  <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      // NOTE: the entry storage is reset on purpose so the head outputs read 0 after
      // reset; a plain RAM without reset would leave ins_data/ins_pc undefined.
      for (int i = 0; i < DEPTH; i++) begin
        ent_pc[i]   <= '0;
        ent_data[i] <= '0;
      end
    end else if (redirect_valid) begin
      // Redirect flushes everything, including the word returning this cycle.
      fetch_pc <= redirect_pc;
      infl_v   <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      infl_v <= issue;
      if (issue) begin
        infl_pc  <= fetch_pc;
        fetch_pc <= fetch_pc + AW'(1);
      end

      if (push) begin
        ent_pc[tail]   <= infl_pc;
        ent_data[tail] <= im_data;
        tail           <= tail + PW'(1);
      end

      if (pop) begin
        head <= head + PW'(1);
      end

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: a one-cycle-latency instruction memory model feeds
// the queue and each scenario task checks handshake outputs against hand-derived values.
module tb_ifetch_queue;

  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk;
  logic          rst_n;
  logic          fetch_en;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic [AW-1:0] im_addr;
  logic [DW-1:0] im_data;
  logic          ins_valid;
  logic [DW-1:0] ins_data;
  logic [AW-1:0] ins_pc;
  logic          ins_ready;

  int checks = 0;
  int errors = 0;

  ifetch_queue #(.DEPTH(4), .AW(AW), .DW(DW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .im_addr        (im_addr),
    .im_data        (im_data),
    .ins_valid      (ins_valid),
    .ins_data       (ins_data),
    .ins_pc         (ins_pc),
    .ins_ready      (ins_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: a few fixed words, a distinct pattern elsewhere.
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    case (a)
      16'd0:   return 16'd33;
      16'd1:   return 16'd38;
      16'd2:   return 16'd6;
      16'd3:   return 16'd0;
      16'd23:  return 16'd43;
      default: return a ^ 16'h5A5A;
    endcase
  endfunction

  // Memory returns mem[addr] one cycle after the address is presented.
  initial im_data = '0;
  always @(posedge clk) im_data <= mem_word(im_addr);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input logic en, input logic rdy);
    rst_n          = 1'b0;
    fetch_en       = 1'b0;
    ins_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    fetch_en  = en;
    ins_ready = rdy;
  endtask

  task automatic expect_head(input string name, input logic [AW-1:0] pc);
    checks++;
    if (ins_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s valid: got %b expected 1", name, ins_valid);
    end
    checks++;
    if (ins_pc !== pc) begin
      errors++;
      $display("FAIL %s pc: got %h expected %h", name, ins_pc, pc);
    end
    checks++;
    if (ins_data !== mem_word(pc)) begin
      errors++;
      $display("FAIL %s data: got %h expected %h", name, ins_data, mem_word(pc));
    end
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    fetch_en       = 1'b1;
    ins_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    step();
    step();
    checks++;
    if (ins_valid !== 1'b0) begin errors++; $display("FAIL reset ins_valid: got %b expected 0", ins_valid); end
    checks++;
    if (ins_data !== '0) begin errors++; $display("FAIL reset ins_data: got %h expected 0", ins_data); end
    checks++;
    if (ins_pc !== '0) begin errors++; $display("FAIL reset ins_pc: got %h expected 0", ins_pc); end
    checks++;
    if (im_addr !== '0) begin errors++; $display("FAIL reset im_addr: got %h expected 0", im_addr); end
  endtask

  task automatic test_sequential();
    apply_reset(1'b1, 1'b1);
    step();
    checks++;
    if (ins_valid !== 1'b0) begin errors++; $display("FAIL seq first-edge valid: got %b expected 0", ins_valid); end
    for (int i = 0; i < 4; i++) begin
      step();
      expect_head($sformatf("seq[%0d]", i), AW'(i));
    end
  endtask

  task automatic test_backpressure();
    apply_reset(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step();
    checks++;
    if (im_addr !== 16'd4) begin errors++; $display("FAIL full im_addr: got %h expected 0004", im_addr); end
    expect_head("full head", 16'd0);
    ins_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      step();
      expect_head($sformatf("drain[%0d]", i), AW'(i));
    end
  endtask

  task automatic test_push_pop();
    apply_reset(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (im_addr !== 16'd4) begin errors++; $display("FAIL pp im_addr E4: got %h expected 0004", im_addr); end
    ins_ready = 1'b1;
    step();
    ins_ready = 1'b0;
    expect_head("pp after pop+push", 16'd1);
    checks++;
    if (im_addr !== 16'd4) begin errors++; $display("FAIL pp no-issue im_addr: got %h expected 0004", im_addr); end
    step();
    checks++;
    if (im_addr !== 16'd5) begin errors++; $display("FAIL pp refill im_addr: got %h expected 0005", im_addr); end
    step();
    checks++;
    if (im_addr !== 16'd5) begin errors++; $display("FAIL pp full im_addr: got %h expected 0005", im_addr); end
    expect_head("pp hold", 16'd1);
    ins_ready = 1'b1;
    for (int i = 2; i < 7; i++) begin
      step();
      expect_head($sformatf("pp order[%0d]", i), AW'(i));
    end
  endtask

  task automatic test_redirect();
    apply_reset(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step();
    expect_head("rd pre", 16'd2);
    redirect_valid = 1'b1;
    redirect_pc    = 16'd23;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (ins_valid !== 1'b0) begin errors++; $display("FAIL rd R+1 valid: got %b expected 0", ins_valid); end
    checks++;
    if (im_addr !== 16'd23) begin errors++; $display("FAIL rd R+1 im_addr: got %h expected 0017", im_addr); end
    step();
    checks++;
    if (ins_valid !== 1'b0) begin errors++; $display("FAIL rd R+2 valid: got %b expected 0", ins_valid); end
    for (int i = 0; i < 3; i++) begin
      step();
      expect_head($sformatf("rd target+%0d", i), AW'(23 + i));
    end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1;
    redirect_pc    = 16'hFFFE;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (im_addr !== 16'hFFFE) begin errors++; $display("FAIL wrap im_addr: got %h expected fffe", im_addr); end
    step();
    step();
    expect_head("wrap 0", 16'hFFFE);
    step();
    expect_head("wrap 1", 16'hFFFF);
    step();
    expect_head("wrap 2", 16'h0000);
  endtask

  task automatic test_async_reset();
    apply_reset(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step();
    expect_head("ar pre", 16'd0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ins_valid !== 1'b0) begin errors++; $display("FAIL async ins_valid: got %b expected 0", ins_valid); end
    checks++;
    if (im_addr !== '0) begin errors++; $display("FAIL async im_addr: got %h expected 0", im_addr); end
    checks++;
    if (ins_pc !== '0) begin errors++; $display("FAIL async ins_pc: got %h expected 0", ins_pc); end
    @(negedge clk);
    rst_n     = 1'b1;
    ins_ready = 1'b1;
    step();
    checks++;
    if (ins_valid !== 1'b0) begin errors++; $display("FAIL async restart E1 valid: got %b expected 0", ins_valid); end
    step();
    expect_head("async restart 0", 16'd0);
    step();
    expect_head("async restart 1", 16'd1);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_push_pop();
    test_redirect();
    test_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
